gate_model_bist: RTL and testbench

Built-in self-test driver for the 24-input / 10-output combinational gate models in the gate library. It generates pseudo-random input patterns with an LFSR, drives them onto the model's inputs, and compacts the model's responses into a MISR signature. At the end of a run it reports pass/fail against a golden signature. It sits on the opposite side of each gate model's pin interface: it drives the model's inputs and consumes the model's outputs.

---
 rtl/gate_model_bist_if.sv | 40 ++++
 rtl/gate_model_bist.sv | 94 +++++++++
 tb/tb_gate_model_bist.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/gate_model_bist_if.sv
// Pin bundle between the BIST driver and one combinational gate model.
// Latency: none, wires only; the model answers stim within the same clock period.
// Backpressure: none; start/abort are levels and the model is always ready.
interface gate_model_bist_if #(
  parameter int NIN  = 24,
  parameter int NOUT = 10
);
  logic            start;
  logic            abort;
  logic [NIN-1:0]  stim;
  logic [NOUT-1:0] resp;
  logic            busy;
  logic            done;
  logic            pass;
  logic [15:0]     signature;

  // BIST side: drives the pattern and status, consumes the model response
  modport master (
    input  start,
    input  abort,
    input  resp,
    output stim,
    output busy,
    output done,
    output pass,
    output signature
  );

  // Environment side: the gate model plus whoever sequences the test
  modport slave (
    output start,
    output abort,
    output resp,
    input  stim,
    input  busy,
    input  done,
    input  pass,
    input  signature
  );
endinterface

// File: rtl/gate_model_bist.sv
// LFSR pattern generator + MISR response compactor for a 24-in/10-out gate model.
// Latency: PATTERNS cycles from the start edge to done; resp is absorbed the same cycle it is produced.
// Backpressure: none; abort (priority over start) drops a run back to IDLE with state frozen.
module gate_model_bist #(
  parameter int             NIN      = 24,
  parameter int             NOUT     = 10,
  parameter int             PATTERNS = 256,
  parameter logic [NIN-1:0] SEED     = 24'h000001,
  parameter logic [15:0]    GOLDEN   = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  gate_model_bist_if.master bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  localparam logic [NIN-1:0] SEED_EFF = (SEED == '0) ? NIN'(1) : SEED;
  localparam logic [15:0]    LAST     = 16'(PATTERNS - 1);

  logic [1:0]     state;
  logic [NIN-1:0] lfsr;
  logic [15:0]    misr;
  logic [15:0]    cnt;

  logic [NIN-1:0] lfsr_nxt;
  logic [15:0]    misr_nxt;
  logic [15:0]    resp_ext;
  logic           lfsr_fb;
  logic           misr_fb;
  logic           launch;

  // Next-state functions of the two shift registers.
  // LFSR x^24+x^23+x^22+x^17+1, MISR x^16+x^14+x^13+x^11+1 with resp folded into the low bits.
  always_comb begin
    resp_ext             = '0;
    resp_ext[NOUT-1:0]   = bus.resp;
    lfsr_fb              = lfsr[23] ^ lfsr[22] ^ lfsr[21] ^ lfsr[16];
    lfsr_nxt             = {lfsr[NIN-2:0], lfsr_fb};
    misr_fb              = misr[15] ^ misr[13] ^ misr[12] ^ misr[10];
    misr_nxt             = {misr[14:0], misr_fb} ^ resp_ext;
  end

  // start is only honoured when no run is in progress; a run in flight ignores it.
  assign launch = bus.start && ((state == S_IDLE) || (state == S_DONE));

  // Sequencer: reload on launch, one pattern per RUN cycle, freeze on abort or completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      lfsr  <= SEED_EFF;
      misr  <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (launch) begin
            state <= S_RUN;
            lfsr  <= SEED_EFF;
            misr  <= '0;
            cnt   <= '0;
          end
        end
        S_RUN: begin
          if (bus.abort) begin
            // Leave lfsr/misr untouched so the partial signature stays visible.
            state <= S_IDLE;
          end else begin
            misr <= misr_nxt;
            lfsr <= lfsr_nxt;
            cnt  <= cnt + 16'd1;
            if (cnt == LAST) begin
              state <= S_DONE;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // The pattern on the model pins is the LFSR itself; no output staging.
  assign bus.stim      = lfsr;
  assign bus.signature = misr;
  assign bus.busy      = (state == S_RUN);
  assign bus.done      = (state == S_DONE);
  assign bus.pass      = (state == S_DONE) && (misr == GOLDEN);

endmodule

// File: tb/tb_gate_model_bist.sv
// Self-checking bench for gate_model_bist: directed cases plus randomized runs vs. a behavioural model.
// Latency: outputs sampled 1 ns after each rising edge.
// Backpressure: n/a; start/abort levels driven from tasks.
module tb_gate_model_bist;

  localparam logic [23:0] SEED_D   = 24'hACE1B5;
  localparam logic [15:0] GOLDEN_D = 16'h0401;
  localparam int          PAT_D    = 40;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  logic [9:0] key_d;

  gate_model_bist_if #(.NIN(24), .NOUT(10)) bus_a ();
  gate_model_bist_if #(.NIN(24), .NOUT(10)) bus_b ();
  gate_model_bist_if #(.NIN(24), .NOUT(10)) bus_c ();
  gate_model_bist_if #(.NIN(24), .NOUT(10)) bus_d ();

  gate_model_bist #(.NIN(24), .NOUT(10), .PATTERNS(4), .SEED(24'h000001), .GOLDEN(16'h000F))
    u_a (.clk(clk), .rst(rst), .bus(bus_a));
  gate_model_bist #(.NIN(24), .NOUT(10), .PATTERNS(1), .SEED(24'h000000), .GOLDEN(16'h0000))
    u_b (.clk(clk), .rst(rst), .bus(bus_b));
  gate_model_bist #(.NIN(24), .NOUT(10), .PATTERNS(2), .SEED(24'h5A5A5A), .GOLDEN(16'h0401))
    u_c (.clk(clk), .rst(rst), .bus(bus_c));
  gate_model_bist #(.NIN(24), .NOUT(10), .PATTERNS(PAT_D), .SEED(SEED_D), .GOLDEN(GOLDEN_D))
    u_d (.clk(clk), .rst(rst), .bus(bus_d));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural reference ----------------
  function automatic logic [23:0] lfsr_step(input logic [23:0] l);
    return {l[22:0], ^(l & 24'hE10000)};
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] m, input logic [9:0] r);
    return {m[14:0], ^(m & 16'hB400)} ^ {6'd0, r};
  endfunction

  // Stand-in combinational gate model for the randomized runs.
  function automatic logic [9:0] gate_fn(input logic [23:0] s, input logic [9:0] k);
    return 10'((s[9:0] ^ s[23:14] ^ k) + {6'd0, s[13:10]});
  endfunction

  function automatic logic [23:0] model_stim(input logic [23:0] seed, input int k);
    logic [23:0] l;
    l = (seed == 24'd0) ? 24'd1 : seed;
    for (int i = 0; i < k; i++) l = lfsr_step(l);
    return l;
  endfunction

  function automatic logic [15:0] model_sig(input logic [23:0] seed, input int n, input logic [9:0] k);
    logic [23:0] l;
    logic [15:0] m;
    l = (seed == 24'd0) ? 24'd1 : seed;
    m = 16'd0;
    for (int i = 0; i < n; i++) begin
      m = misr_step(m, gate_fn(l, k));
      l = lfsr_step(l);
    end
    return m;
  endfunction

  assign bus_d.resp = gate_fn(bus_d.stim, key_d);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    vectors++;
    if (bus_a.stim !== 24'h000001) begin miscompares++; $display("FAIL reset_stim_a got %h exp 000001", bus_a.stim); end
    vectors++;
    if (bus_a.signature !== 16'h0000) begin miscompares++; $display("FAIL reset_sig_a got %h exp 0000", bus_a.signature); end
    vectors++;
    if ({bus_a.busy, bus_a.done, bus_a.pass} !== 3'b000) begin
      miscompares++; $display("FAIL reset_flags_a got %b exp 000", {bus_a.busy, bus_a.done, bus_a.pass});
    end
    vectors++;
    if (bus_b.stim !== 24'h000001) begin miscompares++; $display("FAIL reset_zero_seed got %h exp 000001", bus_b.stim); end
    vectors++;
    if (bus_d.stim !== SEED_D) begin miscompares++; $display("FAIL reset_stim_d got %h exp %h", bus_d.stim, SEED_D); end
  endtask

  task automatic test_lfsr_sequence;
    logic [23:0] tab [4];
    tab = '{24'h000001, 24'h000002, 24'h000004, 24'h000008};
    bus_a.resp = 10'h000;
    bus_a.start = 1'b1; tick; bus_a.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (bus_a.stim !== tab[k] || bus_a.busy !== 1'b1 || bus_a.done !== 1'b0) begin
        miscompares++;
        $display("FAIL lfsr_seq k=%0d got stim=%h busy=%b done=%b exp stim=%h busy=1 done=0",
                 k, bus_a.stim, bus_a.busy, bus_a.done, tab[k]);
      end
      tick;
    end
    vectors++;
    if ({bus_a.busy, bus_a.done, bus_a.pass} !== 3'b010 || bus_a.signature !== 16'h0000) begin
      miscompares++;
      $display("FAIL lfsr_done got bdp=%b sig=%h exp bdp=010 sig=0000",
               {bus_a.busy, bus_a.done, bus_a.pass}, bus_a.signature);
    end
  endtask

  task automatic test_const_resp;
    logic [15:0] tab [4];
    tab = '{16'h0001, 16'h0003, 16'h0007, 16'h000F};
    bus_a.resp = 10'h001;
    bus_a.start = 1'b1; tick; bus_a.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick;
      vectors++;
      if (bus_a.signature !== tab[k]) begin
        miscompares++; $display("FAIL const1_sig k=%0d got %h exp %h", k, bus_a.signature, tab[k]);
      end
    end
    vectors++;
    if (bus_a.done !== 1'b1 || bus_a.pass !== 1'b1) begin
      miscompares++; $display("FAIL const1_pass got done=%b pass=%b exp 1 1", bus_a.done, bus_a.pass);
    end
    bus_c.resp = 10'h3FF;
    bus_c.start = 1'b1; tick; bus_c.start = 1'b0;
    tick; tick;
    vectors++;
    if (bus_c.signature !== 16'h0401 || bus_c.done !== 1'b1 || bus_c.pass !== 1'b1) begin
      miscompares++;
      $display("FAIL const3ff got sig=%h done=%b pass=%b exp 0401 1 1", bus_c.signature, bus_c.done, bus_c.pass);
    end
  endtask

  task automatic test_abort;
    bus_a.resp = 10'h001;
    // abort outside RUN has no effect
    bus_a.abort = 1'b1; tick; bus_a.abort = 1'b0;
    vectors++;
    if (bus_a.done !== 1'b1) begin miscompares++; $display("FAIL abort_in_done got done=%b exp 1", bus_a.done); end
    bus_a.start = 1'b1; tick; bus_a.start = 1'b0;
    tick;
    // start and abort together in RUN: abort wins
    bus_a.start = 1'b1; bus_a.abort = 1'b1; tick; bus_a.start = 1'b0; bus_a.abort = 1'b0;
    vectors++;
    if ({bus_a.busy, bus_a.done, bus_a.pass} !== 3'b000) begin
      miscompares++; $display("FAIL abort_flags got %b exp 000", {bus_a.busy, bus_a.done, bus_a.pass});
    end
    vectors++;
    if (bus_a.signature !== 16'h0001 || bus_a.stim !== 24'h000002) begin
      miscompares++; $display("FAIL abort_hold got sig=%h stim=%h exp 0001 000002", bus_a.signature, bus_a.stim);
    end
    tick; tick;
    vectors++;
    if (bus_a.signature !== 16'h0001 || bus_a.busy !== 1'b0) begin
      miscompares++; $display("FAIL abort_idle got sig=%h busy=%b exp 0001 0", bus_a.signature, bus_a.busy);
    end
    bus_a.start = 1'b1; tick; bus_a.start = 1'b0;
    repeat (4) tick;
    vectors++;
    if (bus_a.signature !== 16'h000F || bus_a.pass !== 1'b1) begin
      miscompares++; $display("FAIL abort_rerun got sig=%h pass=%b exp 000F 1", bus_a.signature, bus_a.pass);
    end
  endtask

  task automatic test_reset_midrun;
    bus_a.resp = 10'h001;
    bus_a.start = 1'b1; tick; bus_a.start = 1'b0;
    tick;
    #3;
    rst = 1'b1;
    #1;
    vectors++;
    if (bus_a.stim !== 24'h000001 || bus_a.signature !== 16'h0000 ||
        {bus_a.busy, bus_a.done, bus_a.pass} !== 3'b000) begin
      miscompares++;
      $display("FAIL rst_async got stim=%h sig=%h bdp=%b exp 000001 0000 000",
               bus_a.stim, bus_a.signature, {bus_a.busy, bus_a.done, bus_a.pass});
    end
    #2;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick;
      vectors++;
      if (bus_a.done !== 1'b0 || bus_a.busy !== 1'b0) begin
        miscompares++; $display("FAIL rst_no_resume i=%0d got done=%b busy=%b exp 0 0", i, bus_a.done, bus_a.busy);
      end
    end
  endtask

  task automatic test_back_to_back;
    bus_b.resp = 10'h155;
    bus_b.start = 1'b1;
    for (int r = 0; r < 2; r++) begin
      tick;
      vectors++;
      if (bus_b.busy !== 1'b1 || bus_b.done !== 1'b0 || bus_b.stim !== 24'h000001 || bus_b.signature !== 16'h0000) begin
        miscompares++;
        $display("FAIL b2b_run r=%0d got busy=%b done=%b stim=%h sig=%h exp 1 0 000001 0000",
                 r, bus_b.busy, bus_b.done, bus_b.stim, bus_b.signature);
      end
      tick;
      vectors++;
      if (bus_b.busy !== 1'b0 || bus_b.done !== 1'b1 || bus_b.signature !== 16'h0155 || bus_b.pass !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b_done r=%0d got busy=%b done=%b sig=%h pass=%b exp 0 1 0155 0",
                 r, bus_b.busy, bus_b.done, bus_b.signature, bus_b.pass);
      end
    end
    bus_b.start = 1'b0;
    tick;
    vectors++;
    if (bus_b.done !== 1'b1 || bus_b.busy !== 1'b0) begin
      miscompares++; $display("FAIL b2b_hold got done=%b busy=%b exp 1 0", bus_b.done, bus_b.busy);
    end
  endtask

  task automatic test_random;
    int          n;
    bit          aborted;
    logic [15:0] exp_sig;
    for (int r = 0; r < 6; r++) begin
      key_d   = 10'($urandom);
      aborted = (r % 2) == 1;
      n       = aborted ? int'($urandom_range(1, PAT_D - 2)) : PAT_D;
      bus_d.start = 1'b1; tick; bus_d.start = 1'b0;
      for (int k = 0; k < n; k++) begin
        vectors++;
        if (bus_d.stim !== model_stim(SEED_D, k)) begin
          miscompares++; $display("FAIL rand_stim r=%0d k=%0d got %h exp %h", r, k, bus_d.stim, model_stim(SEED_D, k));
        end
        tick;
      end
      exp_sig = model_sig(SEED_D, n, key_d);
      if (aborted) begin
        bus_d.abort = 1'b1; tick; bus_d.abort = 1'b0;
        vectors++;
        if (bus_d.signature !== exp_sig || bus_d.busy !== 1'b0 || bus_d.done !== 1'b0) begin
          miscompares++;
          $display("FAIL rand_abort r=%0d n=%0d got sig=%h busy=%b done=%b exp %h 0 0",
                   r, n, bus_d.signature, bus_d.busy, bus_d.done, exp_sig);
        end
      end else begin
        vectors++;
        if (bus_d.signature !== exp_sig || bus_d.done !== 1'b1 || bus_d.pass !== (exp_sig == GOLDEN_D)) begin
          miscompares++;
          $display("FAIL rand_full r=%0d got sig=%h done=%b pass=%b exp %h 1 %b",
                   r, bus_d.signature, bus_d.done, bus_d.pass, exp_sig, exp_sig == GOLDEN_D);
        end
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    key_d       = 10'd0;
    rst         = 1'b1;
    bus_a.start = 1'b0; bus_a.abort = 1'b0; bus_a.resp = 10'd0;
    bus_b.start = 1'b0; bus_b.abort = 1'b0; bus_b.resp = 10'd0;
    bus_c.start = 1'b0; bus_c.abort = 1'b0; bus_c.resp = 10'd0;
    bus_d.start = 1'b0; bus_d.abort = 1'b0;
    #12;
    test_reset;
    rst = 1'b0;
    tick;
    test_lfsr_sequence;
    test_const_resp;
    test_abort;
    test_reset_midrun;
    test_back_to_back;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
